hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  one clock domain; reset is synchronous, active-high.
REQ-003 h_id_valid_i  input  1  ID stage holds a valid instruction.
REQ-004 h_id_rs1_i  input  5  ID source register 1.
REQ-005 h_id_rs2_i  input  5  ID source register 2.
REQ-006 h_ex_valid_i  input  1  EX stage holds a valid instruction.
REQ-007 h_ex_rd_i  input  5  EX destination register.
REQ-008 h_ex_load_i  input  1  EX instruction is a load (register write from memory).
REQ-009 h_branch_i  input  1  decode: conditional branch taken.
REQ-010 h_jal_i  input  1  decode: jal.
REQ-011 h_jalr_i  input  1  decode: jalr.
REQ-012 h_pc_b_i  input  64  branch target.
REQ-013 h_pc_jal_i  input  64  jal target.
REQ-014 h_pc_jalr_i  input  64  jalr target, bit 0 already cleared.
REQ-015 h_mem_wait_i  input  1  memory stage not done this cycle.
REQ-016 h_redirect_o  output  1  load PC from h_pc_target_o.
REQ-017 h_pc_target_o  output  64  registered redirect target.
REQ-018 h_stall_fe_o  output  1  hold PC and IF/ID register.
REQ-019 h_stall_ex_o  output  1  hold ID/EX, EX/MEM, MEM/WB registers.
REQ-020 h_flush_id_o  output  1  clear IF/ID to bubble at next edge.
REQ-021 h_bubble_ex_o  output  1  load bubble into ID/EX at next edge.
REQ-022 h_perf_cnt_o  output  32  stall-cycle counter (see Configuration).

Function
REQ-023 FSM states SHALL be RUN=2'b00, MEM_WAIT=2'b01, REDIRECT=2'b10; 2'b11 SHALL go to RUN next cycle with all control outputs 0.
REQ-024 hazard lu SHALL be h_id_valid_i & h_ex_valid_i & h_ex_load_i & h_ex_rd_i!=0 & (h_id_rs1_i==h_ex_rd_i | h_id_rs2_i==h_ex_rd_i), combinational.
REQ-025 jump = h_id_valid_i & (h_branch_i|h_jal_i|h_jalr_i); target select priority jalr > jal > branch.
REQ-026 RUN, h_mem_wait_i=1: stall_fe=1, stall_ex=1, flush_id=0, bubble_ex=0, jump ignored; next MEM_WAIT.
REQ-027 RUN, no mem wait, lu=1: stall_fe=1, bubble_ex=1, jump ignored; stay RUN.
REQ-028 RUN, no mem wait, lu=0, jump=1: capture target into h_pc_target_o at edge; next REDIRECT; no stall this cycle.
REQ-029 MEM_WAIT: stall_fe=1, stall_ex=1 every cycle; exit to RUN in the cycle after h_mem_wait_i=0 is sampled.
REQ-030 REDIRECT (exactly 1 cycle): redirect=1, flush_id=1, stall_fe=0; bubble_ex=1 if h_mem_wait_i=0, else stall_ex=1, bubble_ex=0 and next MEM_WAIT; otherwise next RUN.
REQ-031 decode inputs SHALL be ignored in REDIRECT (wrong-path instruction in ID); branch penalty fixed at 2 cycles.
REQ-032 h_redirect_o SHALL never be 1 outside REDIRECT; h_pc_target_o holds its value until the next capture.

Reset
REQ-033 rst=1 at an edge: state RUN, h_pc_target_o=0, counter=0; all 1-bit outputs 0 from the following cycle, regardless of state at reset.
REQ-034 rst has priority over every other input, including mid-MEM_WAIT and mid-REDIRECT.

Configuration
REQ-035 HAZARD_PERF_CNT_EN defined: h_perf_cnt_o increments by 1 each cycle with h_stall_fe_o=1, saturating at 32'hFFFF_FFFF.
REQ-036 HAZARD_PERF_CNT_EN undefined: no counter flops; h_perf_cnt_o tied to 0.

Structure
REQ-037 state encodings and counter width SHALL live in the shared define.v include, not locally.
REQ-038 counter SHALL be a sub-module hazard_perf_cnt (clk, rst, inc, cnt), instantiated only under the macro.

Verification
REQ-039 EX lw x5, ID add x6,x5,x1 -> one cycle stall_fe=1, bubble_ex=1, state RUN; x0 as rd -> no stall.
REQ-040 jal in ID, h_pc_jal_i=64'h8000_0100 -> next cycle redirect=1, target=64'h8000_0100, flush_id=1, bubble_ex=1, then RUN.
REQ-041 h_mem_wait_i high 3 cycles from RUN -> stall_fe=stall_ex=1 for 4 cycles, then RUN.
REQ-042 branch and mem wait same cycle -> MEM_WAIT, no redirect; after release, same branch -> REDIRECT.
REQ-043 rst during MEM_WAIT -> next cycle RUN, all outputs 0; with macro, 5 stall cycles -> h_perf_cnt_o=5.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and widths for the hazard controller slice.
// State encodings and the stall-counter width are defined here, not in the modules that use them.
package hazard_ctrl_pkg;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned PC_W       = 64;
    localparam int unsigned PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_REDIRECT = 2'b10,
        ST_RSVD     = 2'b11
    } state_e;

    // Pipeline control bundle, one bit per steering action.
    typedef struct packed {
        logic redirect;
        logic stall_fe;
        logic stall_ex;
        logic flush_id;
        logic bubble_ex;
    } hz_ctrl_t;

    // Load-use: an ID source register reads the destination of a load still in EX.
    function automatic logic load_use(
        input logic             id_valid,
        input logic             ex_valid,
        input logic             ex_load,
        input logic [REG_W-1:0] rs1,
        input logic [REG_W-1:0] rs2,
        input logic [REG_W-1:0] rd
    );
        return id_valid & ex_valid & ex_load & (rd != '0) & ((rs1 == rd) | (rs2 == rd));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
// master is the pipeline side, slave is the hazard controller.
interface hazard_ctrl_if;

    logic                                 h_id_valid_i;
    logic [hazard_ctrl_pkg::REG_W-1:0]    h_id_rs1_i;
    logic [hazard_ctrl_pkg::REG_W-1:0]    h_id_rs2_i;
    logic                                 h_ex_valid_i;
    logic [hazard_ctrl_pkg::REG_W-1:0]    h_ex_rd_i;
    logic                                 h_ex_load_i;
    logic                                 h_branch_i;
    logic                                 h_jal_i;
    logic                                 h_jalr_i;
    logic [hazard_ctrl_pkg::PC_W-1:0]     h_pc_b_i;
    logic [hazard_ctrl_pkg::PC_W-1:0]     h_pc_jal_i;
    logic [hazard_ctrl_pkg::PC_W-1:0]     h_pc_jalr_i;
    logic                                 h_mem_wait_i;
    logic                                 h_redirect_o;
    logic [hazard_ctrl_pkg::PC_W-1:0]     h_pc_target_o;
    logic                                 h_stall_fe_o;
    logic                                 h_stall_ex_o;
    logic                                 h_flush_id_o;
    logic                                 h_bubble_ex_o;
    logic [hazard_ctrl_pkg::PERF_CNT_W-1:0] h_perf_cnt_o;

    modport master (
        output h_id_valid_i, h_id_rs1_i, h_id_rs2_i,
        output h_ex_valid_i, h_ex_rd_i, h_ex_load_i,
        output h_branch_i, h_jal_i, h_jalr_i,
        output h_pc_b_i, h_pc_jal_i, h_pc_jalr_i, h_mem_wait_i,
        input  h_redirect_o, h_pc_target_o, h_stall_fe_o, h_stall_ex_o,
        input  h_flush_id_o, h_bubble_ex_o, h_perf_cnt_o
    );

    modport slave (
        input  h_id_valid_i, h_id_rs1_i, h_id_rs2_i,
        input  h_ex_valid_i, h_ex_rd_i, h_ex_load_i,
        input  h_branch_i, h_jal_i, h_jalr_i,
        input  h_pc_b_i, h_pc_jal_i, h_pc_jalr_i, h_mem_wait_i,
        output h_redirect_o, h_pc_target_o, h_stall_fe_o, h_stall_ex_o,
        output h_flush_id_o, h_bubble_ex_o, h_perf_cnt_o
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Saturating front-end stall-cycle counter.
module hazard_perf_cnt
    import hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    output logic [PERF_CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + PERF_CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, memory-wait stalls and jump redirects.
// Optional stall counter is built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    state_e                state_q;
    state_e                state_d;
    hz_ctrl_t              ctrl;
    logic                  lu;
    logic                  jump;
    logic                  capture;
    logic [PC_W-1:0]       target_sel;
    logic [PC_W-1:0]       target_q;
    logic [PERF_CNT_W-1:0] perf_cnt;

    assign lu   = load_use(hz.h_id_valid_i, hz.h_ex_valid_i, hz.h_ex_load_i,
                           hz.h_id_rs1_i, hz.h_id_rs2_i, hz.h_ex_rd_i);
    assign jump = hz.h_id_valid_i & (hz.h_branch_i | hz.h_jal_i | hz.h_jalr_i);

    // Target priority: jalr over jal over branch.
    always_comb begin
        target_sel = hz.h_pc_b_i;
        if (hz.h_jalr_i) begin
            target_sel = hz.h_pc_jalr_i;
        end else if (hz.h_jal_i) begin
            target_sel = hz.h_pc_jal_i;
        end
    end

    // Next state and control; controls act on the current cycle, so they follow the inputs.
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        capture = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_RUN: begin
                    if (hz.h_mem_wait_i) begin
                        ctrl.stall_fe = 1'b1;
                        ctrl.stall_ex = 1'b1;
                        state_d       = ST_MEM_WAIT;
                    end else if (lu) begin
                        ctrl.stall_fe  = 1'b1;
                        ctrl.bubble_ex = 1'b1;
                    end else if (jump) begin
                        capture = 1'b1;
                        state_d = ST_REDIRECT;
                    end
                end
                ST_MEM_WAIT: begin
                    ctrl.stall_fe = 1'b1;
                    ctrl.stall_ex = 1'b1;
                    if (!hz.h_mem_wait_i) begin
                        state_d = ST_RUN;
                    end
                end
                ST_REDIRECT: begin
                    // ID holds a wrong-path instruction here, so decode inputs are not looked at.
                    ctrl.redirect = 1'b1;
                    ctrl.flush_id = 1'b1;
                    if (hz.h_mem_wait_i) begin
                        ctrl.stall_ex = 1'b1;
                        state_d       = ST_MEM_WAIT;
                    end else begin
                        ctrl.bubble_ex = 1'b1;
                        state_d        = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                target_q <= target_sel;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_perf_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.stall_fe),
        .cnt (perf_cnt)
    );
`else
    assign perf_cnt = '0;
`endif

    assign hz.h_redirect_o  = ctrl.redirect;
    assign hz.h_stall_fe_o  = ctrl.stall_fe;
    assign hz.h_stall_ex_o  = ctrl.stall_ex;
    assign hz.h_flush_id_o  = ctrl.flush_id;
    assign hz.h_bubble_ex_o = ctrl.bubble_ex;
    assign hz.h_pc_target_o = target_q;
    assign hz.h_perf_cnt_o  = perf_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus queues hand-computed expectations,
// a monitor on the falling edge pops and compares them.
module tb_hazard_ctrl;

    localparam logic [63:0] PC_B    = 64'h8000_0200;
    localparam logic [63:0] PC_JAL  = 64'h8000_0100;
    localparam logic [63:0] PC_JALR = 64'h8000_0300;

    // {redirect, stall_fe, stall_ex, flush_id, bubble_ex}
    localparam logic [4:0] C0    = 5'b00000;
    localparam logic [4:0] C_LU  = 5'b01001;
    localparam logic [4:0] C_MW  = 5'b01100;
    localparam logic [4:0] C_RD  = 5'b10011;
    localparam logic [4:0] C_RDM = 5'b10110;

    typedef struct {
        int          id;
        logic [4:0]  ctrl;
        logic [63:0] tgt;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   checks;
    int   passed;
    int   vec_id;

    hazard_ctrl_if hif ();

    hazard_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(
        input logic        r,
        input logic        idv,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic        exv,
        input logic [4:0]  rd,
        input logic        ld,
        input logic        br,
        input logic        jl,
        input logic        jr,
        input logic        mw,
        input logic [4:0]  ec,
        input logic [63:0] et,
        input logic [31:0] ecnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst              = r;
        hif.h_id_valid_i = idv;
        hif.h_id_rs1_i   = rs1;
        hif.h_id_rs2_i   = rs2;
        hif.h_ex_valid_i = exv;
        hif.h_ex_rd_i    = rd;
        hif.h_ex_load_i  = ld;
        hif.h_branch_i   = br;
        hif.h_jal_i      = jl;
        hif.h_jalr_i     = jr;
        hif.h_mem_wait_i = mw;
        vec_id++;
        e.id   = vec_id;
        e.ctrl = ec;
        e.tgt  = et;
`ifdef HAZARD_PERF_CNT_EN
        e.cnt  = ecnt;
`else
        e.cnt  = 32'd0;
`endif
        sb.push_back(e);
    endtask

    task automatic idle(input logic r, input logic mw, input logic [4:0] ec,
                        input logic [63:0] et, input logic [31:0] ecnt);
        step(r, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, mw, ec, et, ecnt);
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    initial begin
        exp_t       e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {hif.h_redirect_o, hif.h_stall_fe_o, hif.h_stall_ex_o,
                       hif.h_flush_id_o, hif.h_bubble_ex_o};
                checks++;
                if (act === e.ctrl && hif.h_pc_target_o === e.tgt && hif.h_perf_cnt_o === e.cnt) begin
                    passed++;
                end else begin
                    $display("FAIL vec%0d: ctrl=%b tgt=%h cnt=%0d, required ctrl=%b tgt=%h cnt=%0d",
                             e.id, act, hif.h_pc_target_o, hif.h_perf_cnt_o, e.ctrl, e.tgt, e.cnt);
                end
            end
        end
    end

    initial begin
        checks = 0;
        passed = 0;
        vec_id = 0;
        rst              = 1'b1;
        hif.h_id_valid_i = 1'b0;
        hif.h_id_rs1_i   = 5'd0;
        hif.h_id_rs2_i   = 5'd0;
        hif.h_ex_valid_i = 1'b0;
        hif.h_ex_rd_i    = 5'd0;
        hif.h_ex_load_i  = 1'b0;
        hif.h_branch_i   = 1'b0;
        hif.h_jal_i      = 1'b0;
        hif.h_jalr_i     = 1'b0;
        hif.h_mem_wait_i = 1'b0;
        hif.h_pc_b_i     = PC_B;
        hif.h_pc_jal_i   = PC_JAL;
        hif.h_pc_jalr_i  = PC_JALR;

        // reset state
        idle(1, 0, C0, 64'd0, 0);
        idle(0, 0, C0, 64'd0, 0);
        // load-use: lw x5 in EX, add x6,x5,x1 in ID
        step(0, 1, 5, 1, 1, 5, 1, 0, 0, 0, 0, C_LU, 64'd0, 0);
        step(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, C0,   64'd0, 1);
        step(0, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0, C0,   64'd0, 1);
        step(0, 1, 2, 7, 1, 7, 1, 0, 0, 0, 0, C_LU, 64'd0, 1);
        step(0, 1, 2, 7, 1, 7, 0, 0, 0, 0, 0, C0,   64'd0, 2);
        step(0, 0, 2, 7, 1, 7, 1, 0, 0, 0, 0, C0,   64'd0, 2);
        // jal redirect; branch in REDIRECT is wrong-path and ignored
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C0,   64'd0, 2);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_RD, PC_JAL, 2);
        idle(0, 0, C0, PC_JAL, 2);
        // load-use wins over jalr
        step(0, 1, 5, 0, 1, 5, 1, 0, 0, 1, 0, C_LU, PC_JAL, 2);
        // jalr > jal > branch; REDIRECT with mem wait
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, C0,   PC_JAL, 3);
        idle(0, 1, C_RDM, PC_JALR, 3);
        idle(0, 0, C_MW,  PC_JALR, 3);
        step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, C0,   PC_JALR, 4);
        idle(0, 0, C_RD, PC_JAL, 4);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C0,   PC_JAL, 4);
        idle(0, 0, C_RD, PC_B, 4);
        // mem wait 3 cycles -> 4 stall cycles
        idle(0, 1, C_MW, PC_B, 4);
        idle(0, 1, C_MW, PC_B, 5);
        idle(0, 1, C_MW, PC_B, 6);
        idle(0, 0, C_MW, PC_B, 7);
        idle(0, 0, C0,   PC_B, 8);
        // branch with mem wait: no capture, then same branch redirects
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C0,   PC_B, 8);
        idle(0, 0, C_RD, PC_JAL, 8);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, C_MW, PC_JAL, 8);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, C_MW, PC_JAL, 9);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C_MW, PC_JAL, 10);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, C0,   PC_JAL, 11);
        idle(0, 0, C_RD, PC_B, 11);
        idle(0, 0, C0,   PC_B, 11);
        // reset mid MEM_WAIT
        idle(0, 1, C_MW, PC_B, 11);
        idle(0, 1, C_MW, PC_B, 12);
        idle(1, 1, C0,   PC_B, 13);
        idle(0, 0, C0,   64'd0, 0);
        // five stall cycles after reset
        idle(0, 1, C_MW, 64'd0, 0);
        idle(0, 1, C_MW, 64'd0, 1);
        idle(0, 1, C_MW, 64'd0, 2);
        idle(0, 1, C_MW, 64'd0, 3);
        idle(0, 0, C_MW, 64'd0, 4);
        idle(0, 0, C0,   64'd0, 5);
        // reset mid REDIRECT
        step(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, C0,   64'd0, 5);
        idle(1, 0, C0, PC_JAL, 5);
        idle(0, 0, C0, 64'd0, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
